// File: rtl/load_unit.sv
// Multi-cycle load unit: one load in flight, word-aligned read from a fixed-latency
// synchronous memory, byte/half/word lane extraction and sign/zero extension.
module load_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_done,
    output logic              ld_err,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for ld_req; inputs sampled only here
    // ISSUE | mem_re/mem_addr presented for one cycle
    // WAIT  | counting down the memory latency
    // DONE  | ld_done pulse; ld_data/ld_err valid
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              err_q;

    logic              accept;
    logic              misaligned;
    logic              capture;
    logic [DATA_W-1:0] lane_data;

    always_comb begin
        misaligned = 1'b0;
        case (ld_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ld_addr[0];
            2'b10:   misaligned = (ld_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Lane select uses the latched address, so later ld_addr changes have no effect.
    always_comb begin
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        lane_data = '0;
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   lane_data = {{(DATA_W-8){signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   lane_data = {{(DATA_W-16){signed_q & half_lane[15]}}, half_lane};
            default: lane_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        ld_done   = 1'b0;
        ld_err    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (ld_req) begin
                    accept    = 1'b1;
                    state_nxt = misaligned ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                mem_re    = 1'b1;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ld_done   = 1'b1;
                ld_err    = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            ld_data  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= ld_addr;
                size_q   <= ld_size;
                signed_q <= ld_signed;
                err_q    <= misaligned;
                if (misaligned) begin
                    ld_data <= '0;
                end
            end
            if (state == ISSUE) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                ld_data <= lane_data;
            end
        end
    end

endmodule
